// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Purpose  : Fetch PC generator with a single-slot pending redirect
//            (exception beats branch). Optional macro PC_ALIGN_CHECK_EN
//            enables the misaligned-PC flag (adel).
// Revision : 1.0  initial release
// ============================================================================
module pc_gen #(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VEC = WIDTH'(32'hbfc00000),
  parameter int unsigned       INC       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallF,
  input  logic             inst_ready,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_valid,
  input  logic [WIDTH-1:0] exc_target,
  output logic [WIDTH-1:0] pc,
  output logic             ce,
  output logic             inst_req,
  output logic             pend,
  output logic             adel
);

  localparam logic [WIDTH-1:0] c_INC = WIDTH'(INC);

  typedef enum logic [0:0] {
    ST_RST = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_ce;
  logic             w_adel;
  logic             w_adv;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_nxt;
  logic             r_pend;
  logic             r_pend_exc;
  logic [WIDTH-1:0] r_pend_tgt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RST;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ce        = 1'b0;
    case (r_state)
      ST_RST: w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_state_nxt = ST_RUN;
        w_ce        = 1'b1;
      end
      default: w_state_nxt = ST_RST;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  assign w_adel = w_ce & (r_pc[1:0] != 2'b00);
`else
  assign w_adel = 1'b0;
`endif

  // A misaligned PC withholds the fetch request, but an exception redirect
  // must still be able to move it, independent of inst_ready.
  assign w_adv = w_ce & ~stallF &
                 ((inst_req & inst_ready) |
                  (w_adel & (exc_valid | (r_pend & r_pend_exc))));

  always_comb begin
    w_pc_nxt = r_pc + c_INC;
    if (exc_valid)                 w_pc_nxt = exc_target;
    else if (r_pend && r_pend_exc) w_pc_nxt = r_pend_tgt;
    else if (br_valid)             w_pc_nxt = br_target;
    else if (r_pend)               w_pc_nxt = r_pend_tgt;
  end

  always_ff @(posedge clk) begin
    if (rst)        r_pc <= RESET_VEC;
    else if (w_adv) r_pc <= w_pc_nxt;
  end

  // A live branch never displaces a pending exception.
  always_ff @(posedge clk) begin
    if (rst || w_adv) begin
      r_pend     <= 1'b0;
      r_pend_exc <= 1'b0;
      r_pend_tgt <= '0;
    end else if (exc_valid) begin
      r_pend     <= 1'b1;
      r_pend_exc <= 1'b1;
      r_pend_tgt <= exc_target;
    end else if (br_valid && !(r_pend && r_pend_exc)) begin
      r_pend     <= 1'b1;
      r_pend_exc <= 1'b0;
      r_pend_tgt <= br_target;
    end
  end

  assign pc       = r_pc;
  assign ce       = w_ce;
  assign inst_req = w_ce & ~w_adel;
  assign pend     = r_pend;
  assign adel     = w_adel;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Purpose  : Directed self-checking bench for pc_gen (default parameters).
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallF = 1'b0;
  logic        inst_ready = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = '0;
  logic        exc_valid = 1'b0;
  logic [31:0] exc_target = '0;
  logic [31:0] pc;
  logic        ce, inst_req, pend, adel;

  int tests = 0;
  int fails = 0;

  pc_gen dut (
    .clk(clk), .rst(rst), .stallF(stallF), .inst_ready(inst_ready),
    .br_valid(br_valid), .br_target(br_target),
    .exc_valid(exc_valid), .exc_target(exc_target),
    .pc(pc), .ce(ce), .inst_req(inst_req), .pend(pend), .adel(adel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++; if (pc !== 32'hbfc00000) begin fails++; $display("FAIL reset_pc got %h want bfc00000", pc); end
      tests++; if ({ce, inst_req, pend, adel} !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b want 0000", {ce, inst_req, pend, adel}); end
    end
    rst = 1'b0;
    step();
    tests++; if (pc !== 32'hbfc00000 || ce !== 1'b1 || inst_req !== 1'b1) begin fails++; $display("FAIL reset_exit got pc=%h ce=%b req=%b want bfc00000 1 1", pc, ce, inst_req); end
    step();
    tests++; if (pc !== 32'hbfc00004) begin fails++; $display("FAIL seq_c2 got %h want bfc00004", pc); end
    step();
    tests++; if (pc !== 32'hbfc00008) begin fails++; $display("FAIL seq_c3 got %h want bfc00008", pc); end
  endtask

  task automatic test_stall();
    step(); step();
    tests++; if (pc !== 32'hbfc00010) begin fails++; $display("FAIL stall_pre got %h want bfc00010", pc); end
    stallF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (pc !== 32'hbfc00010 || inst_req !== 1'b1) begin fails++; $display("FAIL stall_hold got pc=%h req=%b want bfc00010 1", pc, inst_req); end
    end
    stallF = 1'b0;
    step();
    tests++; if (pc !== 32'hbfc00014) begin fails++; $display("FAIL stall_release got %h want bfc00014", pc); end
  endtask

  task automatic test_pending_branch();
    inst_ready = 1'b0; br_valid = 1'b1; br_target = 32'hbfc00100;
    step();
    br_valid = 1'b0;
    tests++; if (pend !== 1'b1 || pc !== 32'hbfc00014) begin fails++; $display("FAIL pend_set got pend=%b pc=%h want 1 bfc00014", pend, pc); end
    step();
    tests++; if (pend !== 1'b1 || pc !== 32'hbfc00014) begin fails++; $display("FAIL pend_hold got pend=%b pc=%h want 1 bfc00014", pend, pc); end
    inst_ready = 1'b1;
    step();
    tests++; if (pc !== 32'hbfc00100 || pend !== 1'b0) begin fails++; $display("FAIL pend_apply got pc=%h pend=%b want bfc00100 0", pc, pend); end
    step();
    tests++; if (pc !== 32'hbfc00104) begin fails++; $display("FAIL pend_after got %h want bfc00104", pc); end
  endtask

  task automatic test_pend_priority();
    stallF = 1'b1;
    br_valid = 1'b1; br_target = 32'hbfc00100; step();
    br_valid = 1'b0; exc_valid = 1'b1; exc_target = 32'hbfc00380; step();
    exc_valid = 1'b0; br_valid = 1'b1; br_target = 32'hbfc00200; step();
    br_valid = 1'b0;
    tests++; if (pend !== 1'b1 || pc !== 32'hbfc00104) begin fails++; $display("FAIL prio_hold got pend=%b pc=%h want 1 bfc00104", pend, pc); end
    stallF = 1'b0;
    step();
    tests++; if (pc !== 32'hbfc00380 || pend !== 1'b0) begin fails++; $display("FAIL prio_apply got pc=%h pend=%b want bfc00380 0", pc, pend); end
  endtask

  task automatic test_same_cycle();
    exc_valid = 1'b1; exc_target = 32'hbfc00380;
    br_valid = 1'b1;  br_target = 32'hbfc00200;
    step();
    exc_valid = 1'b0; br_valid = 1'b0;
    tests++; if (pc !== 32'hbfc00380 || pend !== 1'b0) begin fails++; $display("FAIL same_cycle got pc=%h pend=%b want bfc00380 0", pc, pend); end
    step();
    tests++; if (pc !== 32'hbfc00384) begin fails++; $display("FAIL same_after got %h want bfc00384", pc); end
  endtask

  task automatic test_live_vs_pending();
    stallF = 1'b1; br_valid = 1'b1; br_target = 32'hbfc00100; step();
    stallF = 1'b0; br_target = 32'hbfc00200; step();
    br_valid = 1'b0;
    tests++; if (pc !== 32'hbfc00200 || pend !== 1'b0) begin fails++; $display("FAIL live_br got pc=%h pend=%b want bfc00200 0", pc, pend); end
    stallF = 1'b1; exc_valid = 1'b1; exc_target = 32'hbfc00380; step();
    stallF = 1'b0; exc_valid = 1'b0; br_valid = 1'b1; br_target = 32'hbfc00600; step();
    br_valid = 1'b0;
    tests++; if (pc !== 32'hbfc00380) begin fails++; $display("FAIL pend_exc_wins got %h want bfc00380", pc); end
  endtask

  task automatic test_wrap();
    exc_valid = 1'b1; exc_target = 32'hfffffff8; step();
    exc_valid = 1'b0;
    tests++; if (pc !== 32'hfffffff8) begin fails++; $display("FAIL wrap_load got %h want fffffff8", pc); end
    step();
    tests++; if (pc !== 32'hfffffffc) begin fails++; $display("FAIL wrap_top got %h want fffffffc", pc); end
    step();
    tests++; if (pc !== 32'h00000000 || adel !== 1'b0) begin fails++; $display("FAIL wrap_zero got pc=%h adel=%b want 00000000 0", pc, adel); end
  endtask

  task automatic test_align();
    br_valid = 1'b1; br_target = 32'hbfc00102; step();
    br_valid = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    tests++; if (pc !== 32'hbfc00102 || adel !== 1'b1 || inst_req !== 1'b0) begin fails++; $display("FAIL align_flag got pc=%h adel=%b req=%b want bfc00102 1 0", pc, adel, inst_req); end
    step();
    tests++; if (pc !== 32'hbfc00102) begin fails++; $display("FAIL align_hold got %h want bfc00102", pc); end
    inst_ready = 1'b0; exc_valid = 1'b1; exc_target = 32'hbfc00380; step();
    exc_valid = 1'b0; inst_ready = 1'b1;
    tests++; if (pc !== 32'hbfc00380 || adel !== 1'b0) begin fails++; $display("FAIL align_exc got pc=%h adel=%b want bfc00380 0", pc, adel); end
`else
    tests++; if (pc !== 32'hbfc00102 || adel !== 1'b0 || inst_req !== 1'b1) begin fails++; $display("FAIL align_off got pc=%h adel=%b req=%b want bfc00102 0 1", pc, adel, inst_req); end
    step();
    tests++; if (pc !== 32'hbfc00106) begin fails++; $display("FAIL align_off_adv got %h want bfc00106", pc); end
`endif
  endtask

  task automatic test_reset_mid();
    stallF = 1'b1; br_valid = 1'b1; br_target = 32'hbfc00700; step();
    br_valid = 1'b0; rst = 1'b1; step();
    tests++; if (pc !== 32'hbfc00000 || pend !== 1'b0 || ce !== 1'b0 || inst_req !== 1'b0) begin fails++; $display("FAIL mid_reset got pc=%h pend=%b ce=%b req=%b want bfc00000 0 0 0", pc, pend, ce, inst_req); end
    rst = 1'b0; stallF = 1'b0; step();
    tests++; if (pc !== 32'hbfc00000 || ce !== 1'b1) begin fails++; $display("FAIL mid_exit got pc=%h ce=%b want bfc00000 1", pc, ce); end
    step();
    tests++; if (pc !== 32'hbfc00004) begin fails++; $display("FAIL mid_discard got %h want bfc00004", pc); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_pending_branch();
    test_pend_priority();
    test_same_cycle();
    test_live_vs_pending();
    test_wrap();
    test_align();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter WIDTH, default 32, PC width in bits; legal range 8..64.
REQ-002 Parameter RESET_VEC, default 32'hbfc00000, PC value loaded on reset.
REQ-003 Parameter INC, default 4, sequential PC increment.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 stallF  in  1  fetch stage stall; blocks PC advance.
REQ-007 inst_ready  in  1  instruction memory accepts current request.
REQ-008 br_valid  in  1  branch/jump redirect request.
REQ-009 br_target  in  WIDTH  branch/jump target.
REQ-010 exc_valid  in  1  exception/eret redirect request.
REQ-011 exc_target  in  WIDTH  exception/eret target.
REQ-012 pc  out  WIDTH  current fetch address.
REQ-013 ce  out  1  fetch enable; low during reset.
REQ-014 inst_req  out  1  fetch request, valid with pc.
REQ-015 pend  out  1  a redirect is latched and not yet applied.
REQ-016 adel  out  1  pc misaligned (PC_ALIGN_CHECK_EN only).

Function
REQ-017 The block SHALL define adv = ce & inst_req & inst_ready & ~stallF; pc SHALL change only on a clock edge where adv=1.
REQ-018 inst_req SHALL equal ce (request held continuously, including across stalls, until accepted).
REQ-019 The next pc on adv SHALL be, in priority order: live exc_valid -> exc_target; pending exception -> its target; live br_valid -> br_target; pending branch -> its target; else pc+INC modulo 2^WIDTH.
REQ-020 pc+INC at all-ones-aligned top (e.g. 32'hfffffffc) SHALL wrap to 0 without any flag.
REQ-021 A redirect arriving on a cycle with adv=0 SHALL be latched into a single pending slot (type + target); pend SHALL be 1 from the next cycle.
REQ-022 Pending-slot rules: live exception overwrites a pending branch or exception; live branch overwrites a pending branch; live branch SHALL NOT overwrite a pending exception (it is dropped).
REQ-023 Simultaneous exc_valid and br_valid SHALL act as exc_valid alone.
REQ-024 On adv the pending slot SHALL clear and pend SHALL be 0 on the next cycle, regardless of which source was used.
REQ-025 Redirect applied with adv=1 in the same cycle SHALL take effect in 1 cycle (no latching).
REQ-026 Internal states: RST (ce=0) and RUN (ce=1); RST->RUN on first clock with rst=0; any state->RST on rst=1.

Reset
REQ-027 On a clock edge with rst=1 the block SHALL set pc=RESET_VEC, ce=0, inst_req=0, pend=0, adel=0, clear the pending slot, ignoring all other inputs.
REQ-028 On the first edge with rst=0, ce and inst_req SHALL become 1 with pc still RESET_VEC.
REQ-029 rst asserted mid-operation SHALL discard any pending redirect.

Configuration
REQ-030 Macro PC_ALIGN_CHECK_EN: when defined, adel SHALL be 1 whenever ce=1 and pc[1:0]!=0, and inst_req SHALL be 0 while adel=1 (PC holds until an exception redirect, which is still accepted with ce=1 and stallF=0 regardless of inst_ready).
REQ-031 When PC_ALIGN_CHECK_EN is undefined, adel SHALL be tied 0 and pc alignment SHALL not affect inst_req.

Verification
REQ-032 rst=1 two cycles then 0, inst_ready=1 -> cycle1 pc=bfc00000 ce=1; cycle2 pc=bfc00004; cycle3 pc=bfc00008.
REQ-033 stallF=1 for 3 cycles at pc=bfc00010 -> pc holds bfc00010, inst_req=1 throughout; advances to bfc00014 after release.
REQ-034 inst_ready=0, br_valid pulse target=bfc00100 -> pend=1 next cycle; when inst_ready=1, pc=bfc00100, pend=0.
REQ-035 Pending branch bfc00100 then exc_valid target=bfc00380 while stalled, then br_valid bfc00200 -> on release pc=bfc00380.
REQ-036 Same-cycle exc_valid (bfc00380) and br_valid (bfc00200) with adv=1 -> pc=bfc00380 next cycle, pend=0.
REQ-037 With PC_ALIGN_CHECK_EN, br_target=bfc00102 -> adel=1, inst_req=0; exc_valid target bfc00380 -> pc=bfc00380, adel=0.
